// File: rtl/float8_mac_arbiter.sv
// Round-robin arbiter that time-shares one FP8 dot-product MAC among NUM_REQ
// requesters and returns each bf16 result, tagged with its requester ID, through a FWFT FIFO.
module float8_mac_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int N_WAY      = 16,
    parameter int MAC_LAT    = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*N_WAY*8-1:0] req_X,
    input  logic [NUM_REQ*N_WAY*8-1:0] req_W,
    output logic [N_WAY*8-1:0]         mac_din_X,
    output logic [N_WAY*8-1:0]         mac_din_W,
    output logic                       mac_din_valid,
    input  logic [15:0]                mac_dout,
    input  logic                       mac_dout_valid,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [15:0]                res_data,
    output logic [ID_W-1:0]            res_id,
    output logic                       busy,
    output logic                       err
);
    localparam int VEC_W = N_WAY * 8;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ID_W-1:0]  rr_q, rr_d, gnt_idx, din_id_q;
    logic [OCC_W-1:0] occ_q, occ_d, cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [VEC_W-1:0] din_X_q, din_W_q;
    logic             din_vld_q, err_q, err_d, gnt_any;
    logic             accept, pop, fifo_wr, orphan, missing, tag_last_vld;
    logic [MAC_LAT-1:0] tag_vld_q;
    logic [ID_W-1:0]    tag_id_q [MAC_LAT];
    logic [ID_W+15:0]   fifo_mem [FIFO_DEPTH];

    function automatic logic [ID_W-1:0] rr_cand(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Descending scan so the lowest offset from rr_q wins; gated off while in reset.
    always_comb begin
        req_ready = '0;
        gnt_idx   = rr_q;
        gnt_any   = 1'b0;
        if (rst_n && (occ_q < OCC_W'(FIFO_DEPTH))) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[rr_cand(rr_q, k)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = rr_cand(rr_q, k);
                end
            end
            if (gnt_any) req_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept       = |(req_valid & req_ready);
    assign tag_last_vld = tag_vld_q[MAC_LAT-1];
    assign fifo_wr      = mac_dout_valid & tag_last_vld;
    assign orphan       = mac_dout_valid & ~tag_last_vld;
    assign missing      = tag_last_vld & ~mac_dout_valid;
    assign res_valid    = (cnt_q != '0);
    assign pop          = res_valid & res_ready;

    // A missing MAC result still returns its credit so occ cannot leak.
    always_comb begin
        rr_d  = accept ? rr_cand(gnt_idx, 1) : rr_q;
        occ_d = occ_q;
        if (accept)  occ_d = occ_d + OCC_W'(1);
        if (pop)     occ_d = occ_d - OCC_W'(1);
        if (missing) occ_d = occ_d - OCC_W'(1);
        cnt_d = cnt_q;
        if (fifo_wr) cnt_d = cnt_d + OCC_W'(1);
        if (pop)     cnt_d = cnt_d - OCC_W'(1);
        err_d = err_q | orphan | missing;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            occ_q     <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
            din_vld_q <= 1'b0;
            din_X_q   <= '0;
            din_W_q   <= '0;
            din_id_q  <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s < MAC_LAT; s++) tag_id_q[s] <= '0;
        end else begin
            rr_q      <= rr_d;
            occ_q     <= occ_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            din_vld_q <= accept;
            if (accept) begin
                din_X_q  <= req_X[gnt_idx*VEC_W +: VEC_W];
                din_W_q  <= req_W[gnt_idx*VEC_W +: VEC_W];
                din_id_q <= gnt_idx;
            end
            // Tag pipe is fed from the issue register so its tail lines up with mac_dout_valid.
            tag_vld_q   <= {tag_vld_q[MAC_LAT-2:0], din_vld_q};
            tag_id_q[0] <= din_id_q;
            for (int s = 1; s < MAC_LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
            if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr_q] <= {tag_id_q[MAC_LAT-1], mac_dout};
    end

    assign mac_din_X     = din_X_q;
    assign mac_din_W     = din_W_q;
    assign mac_din_valid = din_vld_q;
    assign res_data      = fifo_mem[rd_ptr_q][15:0];
    assign res_id        = fifo_mem[rd_ptr_q][ID_W+15:16];
    assign busy          = (occ_q != '0);
    assign err           = err_q;

endmodule

// File: tb/tb_float8_mac_arbiter.sv
// Directed bench for float8_mac_arbiter: 3-cycle MAC model, cycle-accurate
// scoreboard of grants and results, plus explicit scenario checks.
module tb_float8_mac_arbiter;
    localparam int NR = 4;
    localparam int NW = 16;
    localparam int VW = NW * 8;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*VW-1:0] req_X = '0;
    logic [NR*VW-1:0] req_W = '0;
    logic [VW-1:0]   mac_din_X, mac_din_W;
    logic            mac_din_valid;
    logic [15:0]     mac_dout;
    logic            mac_dout_valid;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [15:0]     res_data;
    logic [1:0]      res_id;
    logic            busy, err;

    float8_mac_arbiter #(.NUM_REQ(NR), .N_WAY(NW), .MAC_LAT(3), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_X(req_X), .req_W(req_W),
        .mac_din_X(mac_din_X), .mac_din_W(mac_din_W), .mac_din_valid(mac_din_valid),
        .mac_dout(mac_dout), .mac_dout_valid(mac_dout_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in MAC: 3-cycle pipeline computing a 16-bit integer dot product of the lane bytes.
    function automatic logic [15:0] mac_fn(input logic [VW-1:0] x, input logic [VW-1:0] w);
        logic [15:0] acc;
        acc = '0;
        for (int j = 0; j < NW; j++) acc = acc + 16'(16'(x[j*8 +: 8]) * 16'(w[j*8 +: 8]));
        return acc;
    endfunction

    logic [2:0]  mv = '0;
    logic [15:0] md0 = '0, md1 = '0, md2 = '0;
    logic        force_ov = 1'b0;
    always @(posedge clk) begin
        mv  <= {mv[1:0], mac_din_valid};
        md0 <= mac_fn(mac_din_X, mac_din_W);
        md1 <= md0;
        md2 <= md1;
    end
    assign mac_dout_valid = mv[2] | force_ov;
    assign mac_dout       = md2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        logic [1:0]  id;
        int          t;
    } exp_t;

    exp_t q[$];
    int   glog[$];
    int   m_rr = 0;
    int   n_acc = 0, n_pop = 0, first_acc = -1, last_acc = -1, first_rv = -1;
    bit   mon_en = 1'b0;

    // Reference arbiter/FIFO model, evaluated mid-cycle once inputs are stable.
    always @(negedge clk) begin
        logic [NR-1:0] er;
        int   gi;
        bit   mvld;
        exp_t e;
        if (rst_n && mon_en) begin
            er = '0;
            gi = -1;
            if (q.size() < DEPTH)
                for (int k = 0; k < NR; k++)
                    if (gi < 0 && req_valid[(m_rr + k) % NR]) gi = (m_rr + k) % NR;
            if (gi >= 0) er[gi] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("busy", 64'(busy), 64'(q.size() != 0));
            mvld = (q.size() > 0) && (cyc >= q[0].t);
            chk("res_valid", 64'(res_valid), 64'(mvld));
            if (mvld) begin
                chk("res_data", 64'(res_data), 64'(q[0].d));
                chk("res_id", 64'(res_id), 64'(q[0].id));
            end
            if (res_valid && first_rv < 0) first_rv = cyc;
            if (gi >= 0) begin
                e.d  = mac_fn(req_X[gi*VW +: VW], req_W[gi*VW +: VW]);
                e.id = 2'(gi);
                e.t  = cyc + 5;
                q.push_back(e);
                glog.push_back(gi);
                n_acc++;
                m_rr = (gi + 1) % NR;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (mvld && res_ready) begin
                void'(q.pop_front());
                n_pop++;
            end
        end
    end

    task automatic drive_vec();
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < NW; j++) begin
                req_X[(i*NW + j)*8 +: 8] = 8'(cyc*7 + i*37 + j*3 + 1);
                req_W[(i*NW + j)*8 +: 8] = 8'(cyc*13 + i*11 + j*5 + 2);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive_vec();
    endtask

    task automatic clear_model();
        q.delete();
        glog.delete();
        m_rr = 0;
        n_acc = 0;
        n_pop = 0;
        first_acc = -1;
        last_acc = -1;
        first_rv = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
        chk({tag, "_din_valid"}, 64'(mac_din_valid), 64'(0));
        chk({tag, "_din_X"}, 64'(mac_din_X[63:0]), 64'(0));
        chk({tag, "_din_W"}, 64'(mac_din_W[VW-1:VW-64]), 64'(0));
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        clear_model();
        repeat (6) tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        req_valid = '0;
        res_ready = 1'b1;
        for (int k = 0; k < 100 && q.size() != 0; k++) tick();
        tick();
        chk({tag, "_drained_busy"}, 64'(busy), 64'(0));
        chk({tag, "_drained_rv"}, 64'(res_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        req_valid = '1;
        drive_vec();
        #1;
        check_reset_outputs("rst");
        repeat (3) tick();
        req_valid = '0;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Single stream from requester 0
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k < 100 && n_acc < 20; k++) tick();
        req_valid = '0;
        chk("s1_acc", 64'(n_acc), 64'(20));
        chk("s1_back_to_back", 64'(last_acc - first_acc), 64'(19));
        drain("s1");
        chk("s1_pop", 64'(n_pop), 64'(20));
        chk("s1_latency", 64'(first_rv - first_acc), 64'(5));

        // Round-robin over all requesters
        do_reset();
        res_ready = 1'b1;
        req_valid = 4'b1111;
        repeat (12) tick();
        req_valid = '0;
        chk("rr_acc", 64'(n_acc), 64'(12));
        for (int k = 0; k < 8; k++) chk("rr_order", 64'(glog[k]), 64'(k % 4));
        drain("rr");
        chk("rr_pop", 64'(n_pop), 64'(12));

        // Backpressure fills the credit window, then pop-only and pop+accept cycles
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (15) tick();
        chk("bp_acc", 64'(n_acc), 64'(8));
        chk("bp_ready_zero", 64'(req_ready), 64'(0));
        chk("bp_busy", 64'(busy), 64'(1));
        chk("bp_res_valid", 64'(res_valid), 64'(1));
        res_ready = 1'b1;
        tick();
        chk("bp_full_pop_no_acc", 64'(n_acc), 64'(8));
        chk("bp_full_pop", 64'(n_pop), 64'(1));
        tick();
        chk("bp_pop_and_acc", 64'(n_acc), 64'(9));
        chk("bp_pop_and_acc_pop", 64'(n_pop), 64'(2));
        res_ready = 1'b0;
        tick();
        chk("bp_refill", 64'(n_acc), 64'(10));
        tick();
        chk("bp_refull", 64'(n_acc), 64'(10));
        chk("bp_refull_ready", 64'(req_ready), 64'(0));
        drain("bp");
        chk("bp_pop_all", 64'(n_pop), 64'(10));

        // Reset with five requests outstanding
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'b0001;
        for (int k = 0; k < 50 && n_acc < 5; k++) tick();
        chk("mr_acc", 64'(n_acc), 64'(5));
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mr");
        do_reset();
        chk("mr_err_after", 64'(err), 64'(0));
        res_ready = 1'b1;
        req_valid = 4'b0010;
        for (int k = 0; k < 50 && n_acc < 4; k++) tick();
        req_valid = '0;
        chk("mr_new_acc", 64'(n_acc), 64'(4));
        drain("mr");
        chk("mr_new_pop", 64'(n_pop), 64'(4));
        chk("mr_err_clean", 64'(err), 64'(0));

        // Orphan MAC result with nothing issued
        force_ov = 1'b1;
        tick();
        force_ov = 1'b0;
        tick();
        tick();
        chk("orph_err", 64'(err), 64'(1));
        chk("orph_res_valid", 64'(res_valid), 64'(0));
        chk("orph_busy", 64'(busy), 64'(0));
        tick();
        chk("orph_err_sticky", 64'(err), 64'(1));
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("orph_err_cleared", 64'(err), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
